// File: rtl/cl_pack_pkg.sv
// Shared types and helpers for the cache-line result packer.
package cl_pack_pkg;

    localparam int CL_WIDTH_DEFAULT    = 512;
    localparam int COUNT_WIDTH_DEFAULT = 32;

    typedef logic [COUNT_WIDTH_DEFAULT-1:0] count_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } state_t;

    function automatic int words_per_line(input int cl_width, input int word_width);
        return cl_width / word_width;
    endfunction

    // 64-bit intermediates leave headroom above any practical counter width.
    function automatic logic [63:0] ceil_div(input logic [63:0] num, input logic [63:0] den);
        return (num + den - 64'd1) / den;
    endfunction

endpackage

// File: rtl/cl_word_assembler.sv
// Collects words into one cache line, padding unused slots of a short final line.
// Latency: completed line is offered combinationally in the completing accept cycle.
// Backpressure: if the line cannot be taken it is parked and asm_full blocks input.
module cl_word_assembler
    import cl_pack_pkg::*;
#(
    parameter int                    WORD_WIDTH = 64,
    parameter int                    CL_WIDTH   = CL_WIDTH_DEFAULT,
    parameter logic [WORD_WIDTH-1:0] PAD_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  accept,
    input  logic                  last_word,
    input  logic                  take,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  asm_full,
    output logic                  line_vld,
    output logic [CL_WIDTH-1:0]   line_dat
);

    localparam int WPL    = words_per_line(CL_WIDTH, WORD_WIDTH);
    localparam int SLOT_W = (WPL > 1) ? $clog2(WPL) : 1;

    logic [SLOT_W-1:0]   slot;
    logic [CL_WIDTH-1:0] asm_q;
    logic [CL_WIDTH-1:0] line_next;
    logic                complete;

    assign complete = accept && ((slot == SLOT_W'(WPL - 1)) || last_word);

    // Slots above the current one come from PAD_WORD, never from asm_q,
    // so a short line can't carry words left over from the previous line.
    always_comb begin
        line_next = '0;
        for (int k = 0; k < WPL; k++) begin
            if (k < int'(slot)) begin
                line_next[k*WORD_WIDTH +: WORD_WIDTH] = asm_q[k*WORD_WIDTH +: WORD_WIDTH];
            end else if (k == int'(slot)) begin
                line_next[k*WORD_WIDTH +: WORD_WIDTH] = in_data;
            end else begin
                line_next[k*WORD_WIDTH +: WORD_WIDTH] = PAD_WORD;
            end
        end
    end

    assign line_vld = asm_full || complete;
    assign line_dat = asm_full ? asm_q : line_next;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            slot     <= '0;
            asm_q    <= '0;
            asm_full <= 1'b0;
        end else begin
            if (asm_full && take) begin
                asm_full <= 1'b0;
            end
            if (accept) begin
                asm_q <= line_next;
                if (complete) begin
                    slot     <= '0;
                    asm_full <= !take;
                end else begin
                    slot <= slot + SLOT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cl_result_packer.sv
// Packs a run of result words into cache lines for the DMA write port and reports completion.
// Latency: 1 cycle from the completing word accept to out_valid.
// Backpressure: out_ready low holds the output line; a second finished line stalls in_ready.
module cl_result_packer
    import cl_pack_pkg::*;
#(
    parameter int                    WORD_WIDTH  = 64,
    parameter int                    CL_WIDTH    = CL_WIDTH_DEFAULT,
    parameter int                    COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
    parameter logic [WORD_WIDTH-1:0] PAD_WORD    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic [COUNT_WIDTH-1:0] total_words,
    input  logic [WORD_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [CL_WIDTH-1:0]    out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] expected_lines,
    output logic [COUNT_WIDTH-1:0] lines_written,
    output logic                   done
);

    localparam int WPL = words_per_line(CL_WIDTH, WORD_WIDTH);

    typedef logic [COUNT_WIDTH-1:0] cnt_t;

    state_t              state;
    state_t              state_nxt;
    cnt_t                total;
    cnt_t                words_accepted;
    logic                start;
    logic                accept;
    logic                last_word;
    logic                out_hs;
    logic                take;
    logic                asm_full;
    logic                line_vld;
    logic [CL_WIDTH-1:0] line_dat;

    assign start     = go && ((state == IDLE) || (state == DONE));
    assign in_ready  = (state == FILL) && !asm_full && (words_accepted < total);
    assign accept    = in_valid && in_ready;
    assign last_word = accept && ((words_accepted + cnt_t'(1)) == total);
    assign out_hs    = out_valid && out_ready;
    // Output register loads when empty or emptying this same cycle.
    assign take      = line_vld && (!out_valid || out_ready);
    assign done      = (state == DONE);

    cl_word_assembler #(
        .WORD_WIDTH (WORD_WIDTH),
        .CL_WIDTH   (CL_WIDTH),
        .PAD_WORD   (PAD_WORD)
    ) u_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (start),
        .accept    (accept),
        .last_word (last_word),
        .take      (take),
        .in_data   (in_data),
        .asm_full  (asm_full),
        .line_vld  (line_vld),
        .line_dat  (line_dat)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (go) begin
                    state_nxt = (total_words == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (last_word) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs && ((lines_written + cnt_t'(1)) == expected_lines)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            total          <= '0;
            words_accepted <= '0;
            expected_lines <= '0;
            lines_written  <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                total          <= total_words;
                expected_lines <= COUNT_WIDTH'(ceil_div(64'(total_words), 64'(WPL)));
                words_accepted <= '0;
                lines_written  <= '0;
            end else begin
                if (accept) begin
                    words_accepted <= words_accepted + cnt_t'(1);
                end
                if (out_hs) begin
                    lines_written <= lines_written + cnt_t'(1);
                end
            end
            if (take) begin
                out_data  <= line_dat;
                out_valid <= 1'b1;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cl_result_packer.sv
// Bench for cl_result_packer: a 64-bit-word instance and a 32-bit-word instance
// checked every cycle against a run-level model plus hand-computed line contents.
module tb_cl_result_packer;

    bit clk;
    always #5 clk = ~clk;

    logic         rst0, go0, in_valid0, in_ready0, out_valid0, out_ready0, done0;
    logic [31:0]  tw0, el0, lw0;
    logic [63:0]  in_data0;
    logic [511:0] out_data0;

    logic         rst1, go1, in_valid1, in_ready1, out_valid1, out_ready1, done1;
    logic [31:0]  tw1, el1, lw1;
    logic [31:0]  in_data1;
    logic [511:0] out_data1;

    cl_result_packer #(.WORD_WIDTH(64)) u_w64 (
        .clk(clk), .rst(rst0), .go(go0), .total_words(tw0),
        .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .expected_lines(el0), .lines_written(lw0), .done(done0)
    );

    cl_result_packer #(.WORD_WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst1), .go(go1), .total_words(tw1),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .expected_lines(el1), .lines_written(lw1), .done(done1)
    );

    int checks   = 0;
    int failures = 0;

    // Run-level model, one slot per instance.
    int           wpl_of[2] = '{8, 16};
    bit           m_run[2];
    longint       m_total[2], m_lines[2], m_hs[2], m_acc[2];
    int           m_base[2];
    logic         pv[2], pr[2];
    logic [511:0] pd[2], last_line[2];

    task automatic check(input int i, input string nm, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s w%0d t=%0t actual=%0h required=%0h", nm, (i == 0) ? 64 : 32, $time, act, req);
        end
    endtask

    // Word n of a run is base+n; lines are filled slot 0 upward, zero past the end.
    function automatic logic [511:0] exp_line(input int i, input longint j);
        logic [511:0] l;
        int ww;
        longint n;
        l  = '0;
        ww = 512 / wpl_of[i];
        for (int k = 0; k < wpl_of[i]; k++) begin
            n = j * wpl_of[i] + k;
            if (n < m_total[i]) l = l | (512'(longint'(m_base[i]) + n) << (k * ww));
        end
        return l;
    endfunction

    task automatic mon(input int i, input logic go, input logic [31:0] tw, input logic rs,
                       input logic iv, input logic ir, input logic ov, input logic orr,
                       input logic [511:0] od, input logic [31:0] el, input logic [31:0] lw,
                       input logic dn);
        if (m_run[i]) begin
            check(i, "lines_written", lw, m_hs[i]);
            check(i, "expected_lines", el, m_lines[i]);
            check(i, "done", dn, (m_hs[i] == m_lines[i]) ? 1 : 0);
            check(i, "in_ready_past_total", ir && (m_acc[i] >= m_total[i]), 0);
            if (pv[i] && !pr[i]) begin
                check(i, "hold_valid", ov, 1);
                check(i, "hold_data", od, pd[i]);
            end
        end else begin
            check(i, "idle_flags", {ov, dn, ir}, 0);
            check(i, "idle_counts", {el, lw}, 0);
            check(i, "idle_data", od, 0);
        end
        if (rs) begin
            m_run[i] = 1'b0;
            pv[i]    = 1'b0;
        end else begin
            if (go && (!m_run[i] || (m_hs[i] == m_lines[i] && m_acc[i] == m_total[i]))) begin
                m_run[i]   = 1'b1;
                m_total[i] = longint'(tw);
                m_lines[i] = (m_total[i] + wpl_of[i] - 1) / wpl_of[i];
                m_hs[i]    = 0;
                m_acc[i]   = 0;
            end else if (m_run[i]) begin
                if (iv && ir) m_acc[i]++;
                if (ov && orr) begin
                    check(i, "line_in_range", m_hs[i] < m_lines[i], 1);
                    check(i, "line_data", od, exp_line(i, m_hs[i]));
                    last_line[i] = od;
                    m_hs[i]++;
                end
            end
            pv[i] = ov;
            pr[i] = orr;
            pd[i] = od;
        end
    endtask

    always @(negedge clk) begin
        mon(0, go0, tw0, rst0, in_valid0, in_ready0, out_valid0, out_ready0, out_data0, el0, lw0, done0);
        mon(1, go1, tw1, rst1, in_valid1, in_ready1, out_valid1, out_ready1, out_data1, el1, lw1, done1);
    end

    // hold: cycles with out_ready low; rst_after: pulse rst after that many accepts.
    task automatic run0(input int total, input int base, input int hold, input int rst_after, input bit strict);
        int n, cyc, stalls;
        bit acc;
        m_base[0]  = base;
        tw0        = 32'(total);
        go0        = 1'b1;
        in_valid0  = 1'b0;
        out_ready0 = (hold == 0);
        @(posedge clk); #1;
        go0       = 1'b0;
        n         = 0;
        cyc       = 0;
        stalls    = 0;
        in_data0  = 64'(base);
        in_valid0 = (total > 0);
        while (!done0 && cyc < 400) begin
            @(negedge clk);
            acc = in_valid0 && in_ready0;
            if (in_valid0 && !in_ready0) stalls++;
            if (hold > 0 && cyc == hold - 1) begin
                check(0, "hold_in_ready_low", in_ready0, 0);
                check(0, "hold_words_taken", n, total);
                check(0, "hold_out_valid", out_valid0, 1);
                check(0, "hold_line0_slot7", out_data0[511:448], base + 7);
            end
            @(posedge clk); #1;
            if (acc) n++;
            cyc++;
            out_ready0 = (cyc >= hold);
            in_valid0  = (n < total);
            in_data0   = 64'(base + n);
            if (rst_after > 0 && n == rst_after) begin
                in_valid0 = 1'b0;
                rst0      = 1'b1;
                @(posedge clk); #1;
                rst0 = 1'b0;
                return;
            end
        end
        check(0, "run_completes", done0, 1);
        if (strict) check(0, "no_stall_in_run", stalls, 0);
        in_valid0 = 1'b0;
    endtask

    task automatic run1(input int total, input int base);
        int n, cyc;
        bit acc;
        m_base[1]  = base;
        tw1        = 32'(total);
        go1        = 1'b1;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        @(posedge clk); #1;
        go1 = 1'b0;
        n   = 0;
        cyc = 0;
        in_data1  = 32'(base);
        in_valid1 = 1'b1;
        while (!done1 && cyc < 2000) begin
            @(negedge clk);
            acc = in_valid1 && in_ready1;
            @(posedge clk); #1;
            if (acc) n++;
            cyc++;
            out_ready1 = ($urandom_range(0, 3) != 0);
            in_valid1  = (n < total) && ($urandom_range(0, 2) != 0);
            in_data1   = 32'(base + n);
        end
        check(1, "run_completes", done1, 1);
        check(1, "words_sent", n, total);
        in_valid1 = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; go0 = 1'b0; tw0 = '0; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
        rst1 = 1'b1; go1 = 1'b0; tw1 = '0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        fork
            begin
                run0(16, 0, 0, 0, 1);
                check(0, "t1_expected_lines", el0, 2);
                check(0, "t1_lines_written", lw0, 2);
                check(0, "t1_line1_slot0", last_line[0][63:0], 8);
                check(0, "t1_line1_slot7", last_line[0][511:448], 15);

                run0(11, 0, 0, 0, 0);
                check(0, "t2_expected_lines", el0, 2);
                check(0, "t2_lines_written", lw0, 2);
                check(0, "t2_line1_slot2", last_line[0][191:128], 10);
                check(0, "t2_line1_pad", last_line[0][511:192], 0);

                run0(16, 0, 30, 0, 0);
                check(0, "t3_lines_written", lw0, 2);
                check(0, "t3_line1_slot7", last_line[0][511:448], 15);

                run0(0, 0, 0, 0, 0);
                check(0, "t4_expected_lines", el0, 0);
                check(0, "t4_done_next_cycle", done0, 1);
                run0(8, 200, 0, 0, 1);
                check(0, "t4_rerun_lines", lw0, 1);
                check(0, "t4_rerun_slot0", last_line[0][63:0], 200);

                run0(16, 0, 0, 5, 0);
                @(negedge clk);
                check(0, "t5_rst_flags", {out_valid0, in_ready0, done0}, 0);
                check(0, "t5_rst_counts", {el0, lw0}, 0);
                check(0, "t5_rst_data", out_data0, 0);
                run0(8, 100, 0, 0, 1);
                check(0, "t5_clean_slot0", last_line[0][63:0], 100);
                check(0, "t5_clean_slot7", last_line[0][511:448], 107);
                check(0, "t5_clean_lines", lw0, 1);
            end
            begin
                run1(20, 0);
                check(1, "r_expected_lines", el1, 2);
                check(1, "r_lines_written", lw1, 2);
                check(1, "r_line1_slot0", last_line[1][31:0], 16);
                check(1, "r_line1_slot3", last_line[1][127:96], 19);
                check(1, "r_line1_pad", last_line[1][511:128], 0);
                run1(16, 300);
                check(1, "r_full_line_count", lw1, 1);
                check(1, "r_full_line_slot15", last_line[1][511:480], 315);
            end
        join
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
